// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code consumers: FSM encoding and default sizing.
package johnson_pkg;

   localparam int unsigned DEFAULT_N     = 4;
   localparam int unsigned DEFAULT_IDX_W = $clog2(2 * DEFAULT_N);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code check and decode: code -> {legal, index}.
module johnson_code_decode
   import johnson_pkg::*;
#(
   parameter int unsigned N = DEFAULT_N
) (
   input  logic [N-1:0]            code,
   output logic                    legal,
   output logic [$clog2(2*N)-1:0] index
);

   localparam int unsigned IW = $clog2(2 * N);

   int unsigned ones;
   int unsigned edges;

   always_comb begin
      ones  = 0;
      edges = 0;
      for (int unsigned i = 0; i < N; i++) begin
         ones = ones + {31'b0, code[i]};
      end
      for (int unsigned i = 0; i + 1 < N; i++) begin
         edges = edges + {31'b0, code[i+1] ^ code[i]};
      end
      legal = (edges <= 1);
      // Upper half of the ring counts ones down from 2N.
      if (!code[N-1]) begin
         index = IW'(ones);
      end else begin
         index = IW'(2 * N - ones);
      end
   end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: tracks lock, step direction, signed position and error count.
module johnson_decoder
   import johnson_pkg::*;
#(
   parameter int unsigned N     = DEFAULT_N,
   parameter int unsigned POS_W = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [N-1:0]            code_in,
   input  logic                    clear_errors,
   output logic [$clog2(2*N)-1:0] index,
   output logic                    step_up,
   output logic                    step_down,
   output logic                    illegal,
   output logic                    jump,
   output logic                    locked,
   output logic [POS_W-1:0]        position,
   output logic [7:0]              err_count
);

   localparam int unsigned IW     = $clog2(2 * N);
   localparam int unsigned STATES = 2 * N;

   state_t        state_q;
   logic          legal;
   logic [IW-1:0] new_index;
   int unsigned   delta;
   logic          is_hold, is_up, is_down;
   logic          err_event;
   logic [7:0]    err_d;

   johnson_code_decode #(
      .N(N)
   ) u_decode (
      .code  (code_in),
      .legal (legal),
      .index (new_index)
   );

   always_comb begin
      if (new_index >= index) begin
         delta = 32'(new_index - index);
      end else begin
         delta = 32'(new_index) + STATES - 32'(index);
      end
      is_hold   = (delta == 0);
      is_up     = (delta == 1);
      is_down   = (delta == STATES - 1);
      err_event = in_valid &&
                  (!legal || (state_q == ST_LOCKED && !is_hold && !is_up && !is_down));
      // A clear coinciding with a new error leaves that error counted.
      err_d = err_count;
      if (clear_errors) begin
         err_d = {7'b0, err_event};
      end else if (err_event && err_count != 8'hFF) begin
         err_d = err_count + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_UNLOCKED;
         index     <= '0;
         position  <= '0;
         err_count <= '0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         illegal   <= 1'b0;
         jump      <= 1'b0;
      end else begin
         step_up   <= 1'b0;
         step_down <= 1'b0;
         illegal   <= 1'b0;
         jump      <= 1'b0;
         err_count <= err_d;
         if (in_valid) begin
            if (!legal) begin
               illegal <= 1'b1;
               state_q <= ST_UNLOCKED;
            end else begin
               case (state_q)
                  ST_UNLOCKED: begin
                     index   <= new_index;
                     state_q <= ST_LOCKED;
                  end
                  ST_LOCKED: begin
                     if (is_up) begin
                        index    <= new_index;
                        position <= position + POS_W'(1);
                        step_up  <= 1'b1;
                     end else if (is_down) begin
                        index     <= new_index;
                        position  <= position - POS_W'(1);
                        step_down <= 1'b1;
                     end else if (!is_hold) begin
                        jump    <= 1'b1;
                        state_q <= ST_UNLOCKED;
                     end
                  end
                  default: state_q <= ST_UNLOCKED;
               endcase
            end
         end
      end
   end

   assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder (N=4, POS_W=16): vector table, corner sequences, random vs model.
module tb_johnson_decoder;

   localparam int NS = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] code_in = 4'b0;
   logic       clear_errors = 1'b0;
   logic [2:0] index;
   logic       step_up, step_down, illegal, jump, locked;
   logic [15:0] position;
   logic [7:0] err_count;

   johnson_decoder #(
      .N     (4),
      .POS_W (16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .code_in      (code_in),
      .clear_errors (clear_errors),
      .index        (index),
      .step_up      (step_up),
      .step_down    (step_down),
      .illegal      (illegal),
      .jump         (jump),
      .locked       (locked),
      .position     (position),
      .err_count    (err_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      bit         v;
      logic [3:0] code;
      bit         clr;
      int lk; int ix; int ps; int up; int dn; int il; int jp; int er;
   } vec_t;
   vec_t tbl[$];

   // Reference model: ring of codes generated from the sequence definition.
   logic [3:0] seq[NS];
   int m_locked, m_index, m_pos, m_err;
   int e_up, e_dn, e_il, e_jp;

   function automatic int lookup(input logic [3:0] c);
      for (int i = 0; i < NS; i++) if (seq[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_index = 0; m_pos = 0; m_err = 0;
      e_up = 0; e_dn = 0; e_il = 0; e_jp = 0;
   endtask

   task automatic model_step(input bit v, input logic [3:0] c, input bit clr);
      int idx, d;
      bit ev;
      ev = 0; e_up = 0; e_dn = 0; e_il = 0; e_jp = 0;
      if (v) begin
         idx = lookup(c);
         if (idx < 0) begin
            e_il = 1; ev = 1; m_locked = 0;
         end else if (m_locked == 0) begin
            m_locked = 1; m_index = idx;
         end else begin
            d = (idx - m_index + NS) % NS;
            if (d == 1) begin
               e_up = 1; m_index = idx; m_pos = m_pos + 1;
            end else if (d == NS - 1) begin
               e_dn = 1; m_index = idx; m_pos = m_pos - 1;
            end else if (d != 0) begin
               e_jp = 1; ev = 1; m_locked = 0;
            end
         end
      end
      if (m_pos > 32767) m_pos = m_pos - 65536;
      if (m_pos < -32768) m_pos = m_pos + 65536;
      if (clr) m_err = ev ? 1 : 0;
      else if (ev && m_err < 255) m_err = m_err + 1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int lk, input int ix, input int ps,
                             input int up, input int dn, input int il, input int jp,
                             input int er);
      chk({tag, ".locked"}, int'(locked), lk);
      chk({tag, ".index"}, int'(index), ix);
      chk({tag, ".position"}, $signed(position), ps);
      chk({tag, ".step_up"}, int'(step_up), up);
      chk({tag, ".step_down"}, int'(step_down), dn);
      chk({tag, ".illegal"}, int'(illegal), il);
      chk({tag, ".jump"}, int'(jump), jp);
      chk({tag, ".err_count"}, int'(err_count), er);
   endtask

   task automatic check_model(input string tag);
      check_outs(tag, m_locked, m_index, m_pos, e_up, e_dn, e_il, e_jp, m_err);
   endtask

   task automatic drive(input bit v, input logic [3:0] c, input bit clr, input bit rst_n);
      @(negedge clock);
      reset = rst_n; in_valid = v; code_in = c; clear_errors = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic run(input bit v, input logic [3:0] c, input bit clr, input bit rst_n);
      drive(v, c, clr, rst_n);
      if (!rst_n) model_reset();
      else model_step(v, c, clr);
   endtask

   task automatic add(input bit v, input logic [3:0] c, input bit clr, input int lk,
                      input int ix, input int ps, input int up, input int dn,
                      input int il, input int jp, input int er);
      vec_t r;
      r.v = v; r.code = c; r.clr = clr; r.lk = lk; r.ix = ix; r.ps = ps;
      r.up = up; r.dn = dn; r.il = il; r.jp = jp; r.er = er;
      tbl.push_back(r);
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         if (i <= 4) seq[i] = 4'((1 << i) - 1);
         else seq[i] = 4'(15 & ~((1 << (i - 4)) - 1));
      end

      //   v  code     clr lk ix  ps up dn il jp er
      add(1, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 4'b0001, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      add(1, 4'b0011, 0, 1, 2, 2, 1, 0, 0, 0, 0);
      add(1, 4'b0111, 0, 1, 3, 3, 1, 0, 0, 0, 0);
      add(1, 4'b1111, 0, 1, 4, 4, 1, 0, 0, 0, 0);
      add(1, 4'b1110, 0, 1, 5, 5, 1, 0, 0, 0, 0);
      add(1, 4'b1100, 0, 1, 6, 6, 1, 0, 0, 0, 0);
      add(1, 4'b1000, 0, 1, 7, 7, 1, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 8, 1, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 8, 0, 0, 0, 0, 0);
      add(1, 4'b1000, 0, 1, 7, 7, 0, 1, 0, 0, 0);
      add(1, 4'b1100, 0, 1, 6, 6, 0, 1, 0, 0, 0);
      add(1, 4'b1110, 0, 1, 5, 5, 0, 1, 0, 0, 0);
      add(1, 4'b1111, 0, 1, 4, 4, 0, 1, 0, 0, 0);
      add(1, 4'b0111, 0, 1, 3, 3, 0, 1, 0, 0, 0);
      add(1, 4'b0011, 0, 1, 2, 2, 0, 1, 0, 0, 0);
      add(1, 4'b1110, 0, 0, 2, 2, 0, 0, 0, 1, 1);
      add(1, 4'b1110, 0, 1, 5, 2, 0, 0, 0, 0, 1);
      add(1, 4'b0110, 1, 0, 5, 2, 0, 0, 1, 0, 1);
      add(1, 4'b0110, 0, 0, 5, 2, 0, 0, 1, 0, 2);
      add(1, 4'b1100, 0, 1, 6, 2, 0, 0, 0, 0, 2);
      add(0, 4'b1000, 0, 1, 6, 2, 0, 0, 0, 0, 2);
      add(1, 4'b1100, 1, 1, 6, 2, 0, 0, 0, 0, 0);
      add(1, 4'b1000, 0, 1, 7, 3, 1, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 1, 0, 4, 1, 0, 0, 0, 0);
      add(1, 4'b1000, 0, 1, 7, 3, 0, 1, 0, 0, 0);
      add(1, 4'b0100, 0, 0, 7, 3, 0, 0, 1, 0, 1);

      drive(0, 4'b0000, 0, 0);
      drive(1, 4'b1111, 1, 0);
      check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].code, tbl[k].clr, 1);
         check_outs($sformatf("vec%0d", k), tbl[k].lk, tbl[k].ix, tbl[k].ps, tbl[k].up,
                    tbl[k].dn, tbl[k].il, tbl[k].jp, tbl[k].er);
      end

      // Mid-stream reset with a valid sample present, then reacquire without stepping.
      drive(1, 4'b0000, 0, 0);
      drive(1, 4'b0000, 0, 1);
      drive(1, 4'b0001, 0, 1);
      drive(1, 4'b0011, 0, 1);
      drive(1, 4'b0111, 0, 0);
      check_outs("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 4'b0111, 0, 1);
      check_outs("relock", 1, 3, 0, 0, 0, 0, 0, 0);

      // Error counter saturation.
      run(0, 4'b0000, 0, 0);
      for (int i = 0; i < 260; i++) run(1, 4'b0110, 0, 1);
      check_model("sat");
      chk("sat.const", int'(err_count), 255);
      run(1, 4'b0101, 1, 1);
      check_model("sat_clear_err");

      // Position wrap at the signed boundary.
      run(0, 4'b0000, 0, 0);
      run(1, 4'b0000, 0, 1);
      for (int i = 1; i <= 32767; i++) run(1, seq[i % NS], 0, 1);
      chk("wrap.max", $signed(position), 32767);
      run(1, seq[0], 0, 1);
      chk("wrap.min", $signed(position), -32768);
      check_model("wrap");

      // Randomized traffic against the model.
      run(0, 4'b0000, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [3:0] c;
         r = $urandom_range(99);
         if (r < 60 && m_locked != 0) c = seq[(m_index + $urandom_range(2) + NS - 1) % NS];
         else if (r < 85) c = seq[$urandom_range(NS - 1)];
         else c = 4'($urandom_range(15));
         run($urandom_range(9) != 0, c, $urandom_range(19) == 0, $urandom_range(99) != 0);
         check_model($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the team's Johnson-code up/down counter. Samples an N-bit Johnson code each valid cycle, decodes it to a binary index, and infers step direction from consecutive samples. Accumulates a signed position, flags illegal codes and skipped states, and tracks lock status and error count. Sits downstream of any Johnson-coded source, for example a counter output crossing a block boundary or an encoder ring.

## Interface
Parameters:
- N, 4, Johnson code width; the sequence has 2N states (N ≥ 2).
- POS_W, 16, width of the signed position accumulator.

Ports:
- clock  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-low reset (sampled on rising clock).
- in_valid  in  1  code_in is sampled this cycle.
- code_in  in  N  Johnson code sample.
- clear_errors  in  1  zeroes err_count.
- index  out  clog2(2N)  decoded state index of last legal sample.
- step_up  out  1  one-cycle pulse: a +1 step was accepted.
- step_down  out  1  one-cycle pulse: a −1 step was accepted.
- illegal  out  1  one-cycle pulse: sampled code is not a Johnson code.
- jump  out  1  one-cycle pulse: legal code, but |delta| > 1.
- locked  out  1  decoder has a valid reference state.
- position  out  POS_W  signed two's-complement step accumulator.
- err_count  out  8  saturating count of illegal and jump events.

## Operation
- Up sequence (N=4), index 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. Each up step is {code[N-2:0], ~code[N-1]}.
- Legal code: at most one adjacent-bit transition, i.e. popcount(code[N-1:1] ^ code[N-2:0]) ≤ 1.
- Decode: if msb=0, index = popcount(code); otherwise index = 2N − popcount(code).
- delta = (new_index − index) mod 2N:
  - 0 → hold.
  - 1 → up.
  - 2N−1 → down.
  - anything else → jump.
- FSM has two states, UNLOCKED and LOCKED.
- UNLOCKED, valid legal sample: load index, go LOCKED. No step pulse; position unchanged.
- UNLOCKED, valid illegal sample: pulse illegal, increment err_count, stay UNLOCKED.
- LOCKED, valid sample:
  - hold → nothing changes.
  - up → index updated, position +1, step_up.
  - down → index updated, position −1, step_down.
  - jump → jump pulse, err_count +1, go UNLOCKED; index and position unchanged.
  - illegal → illegal pulse, err_count +1, go UNLOCKED.
- in_valid=0: no state change, all pulses 0.
- position wraps modulo 2^POS_W; no saturation.
- position is preserved across loss of lock and relock.
- Index wrap is a normal step in both directions (2N−1 → 0 is up, 0 → 2N−1 is down).
- err_count saturates at 255.
- clear_errors and an error event in the same cycle → err_count = 1.
- clear_errors alone → err_count = 0.

## Timing
- All outputs are registered. A sample taken at edge t is reflected in outputs after edge t (one-cycle latency).
- Pulses are high for exactly one cycle per accepted sample.
- Back-to-back valid samples every cycle are supported, with full throughput.
- Reset values: index=0, position=0, locked=0, err_count=0, all pulses 0, FSM=UNLOCKED.
- Reset asserted mid-stream overrides all inputs that cycle. The first valid sample after reset only acquires lock.

## Structure
- Package johnson_pkg:
  - FSM state encoding (ST_UNLOCKED, ST_LOCKED).
  - Default N.
  - Index-width constant derived as clog2(2N).
- Sub-module johnson_code_decode: purely combinational, code_in → {legal, index}. Reusable by other Johnson consumers.
- Top level holds the FSM, delta compare, position accumulator and error counter.

## Test plan
- Reset, then valid 0000: locked=1, index=0, position=0, no pulse.
- Up sweep 0000→0001→…→1000→0000 (9 samples): 8 step_up pulses, position=8, index=0.
- Down sweep from locked 0000 through 1000, 1100: step_down ×2, position=−2, index=6.
- Locked at 0011, sample 1110: jump=1, locked=0, err_count=1, position held. Then 1110 again: relock, index=5, no step.
- Sample 0110: illegal=1, err_count+1, locked=0. Same cycle with clear_errors=1: err_count=1.
- position at 32767 (POS_W=16), one up step → −32768. Reset mid-sweep → all outputs zero next cycle.
